target_scheduler: RTL
=====================

Name: target_scheduler

Overview:
- Hardware game sequencer that drives the two target slots (A, B) and the three shared countdown timers.
- Replaces the software game loop for target spawning, timeout and scoring.
- Sits between the random number generator, the per-slot hit checkers and the timer blocks.
- Its target and score outputs feed the target LEDs and the score converter directly.

Parameters:
- NUM_TARGETS, 10: valid target indices are 0..NUM_TARGETS-1.
- NO_TARGET, 4'hF: encoding for an empty slot.
- TARGET_LEN, 32'd50_000_000: timer length loaded for each target lifetime, in clocks.
- GAME_LEN, 32'd1_500_000_000: timer length loaded for the whole game, in clocks.
- HIT_POINTS, 1: score increment per hit.
- RESPAWN_GAP, 8: idle clocks between a slot clearing and its next spawn.

Ports:
- clock, in, 1: master clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start_game, in, 1: level; sampled only in IDLE and OVER.
- rand_num, in, 4: random value, may change every cycle.
- hit_a, in, 1: the current target_a is hit (level, from the slot A hit checker).
- hit_b, in, 1: the current target_b is hit.
- timer_done_a / timer_done_b / timer_done_c, in, 1 each: timer expired (level).
- timer_start_a / timer_start_b / timer_start_c, out, 1 each: one-clock load/start pulse.
- timer_len_a / timer_len_b / timer_len_c, out, 32 each: length presented with the start pulse.
- target_a, target_b, out, 4 each: active target index, or NO_TARGET.
- score, out, 32: running score.
- game_over, out, 1: high while in OVER.
- playing, out, 1: high while in PLAY.

Behaviour:
- Reset (asynchronous, reset=0):
  - top state IDLE, both slots EMPTY;
  - target_a = target_b = NO_TARGET;
  - score = 0, all timer_start = 0;
  - timer_len outputs = 0;
  - game_over = 0, playing = 0;
  - gap counters = 0.
- Reset asserted mid-game aborts immediately. No start pulse is emitted in the release cycle.
- Top FSM: IDLE -> PLAY -> OVER.
  - IDLE to PLAY on start_game=1. In that same edge: score cleared, timer_start_c pulsed with timer_len_c = GAME_LEN, both slots set to SPAWN.
  - PLAY to OVER when timer_done_c=1, sampled no earlier than 2 clocks after the start_c pulse (timer blanking window). On entry both targets go to NO_TARGET, slots go EMPTY, and score freezes.
  - OVER to PLAY on start_game=1, with the same actions as leaving IDLE.
- Slot FSM (X = A uses timer a and hit_a; X = B uses timer b and hit_b): EMPTY, SPAWN, ACTIVE, GAP.
  - SPAWN: each cycle rand_num is accepted only if it is < NUM_TARGETS and differs from the other slot's current target.
    - On accept: target_X = rand_num, timer_start_X pulsed for 1 clock with timer_len_X = TARGET_LEN, go to ACTIVE.
    - On reject: stay in SPAWN and retry next clock.
  - Both slots in SPAWN in the same cycle: A has priority. B's candidate is compared against A's newly accepted value and is rejected if equal.
  - ACTIVE, hit_X=1: score += HIT_POINTS, target_X = NO_TARGET, go to GAP.
  - ACTIVE, timer_done_X=1 after the 2-clock blanking window: target_X = NO_TARGET, no score change, go to GAP.
  - ACTIVE, hit and done in the same cycle: the hit wins and is scored.
  - ACTIVE, hit_X during the blanking window: counted.
  - GAP: counts RESPAWN_GAP clocks, then goes to SPAWN.
- Hit on both slots in one cycle: score += 2*HIT_POINTS in a single update.
- Game end in the same cycle as a hit: the game end wins, the hit is not scored.
- Score arithmetic: 32-bit unsigned, wraps modulo 2^32, no saturation.
- Start pulses are registered outputs: high exactly one clock, never back-to-back on the same timer.
- Hits and timeouts are ignored outside PLAY.

Optional Feature:
- Macro: TARGET_SPEEDUP_EN.
- When defined, the target lifetime shrinks as the score grows:
  - timer_len_a/b = TARGET_LEN >> min(score[31:3], 3), so the lifetime halves every 8 points down to TARGET_LEN/8;
  - the length is latched at the spawn cycle.
- When undefined, timer_len_a/b is always TARGET_LEN and no shifter is synthesized.

Test Plan:
- Reset, then start_game=1 for 1 clock: timer_start_c pulses once with len=GAME_LEN, playing=1, score=0. With rand_num=3 then 5, target_a=3 and target_b=5 within 2 clocks, and timer_start_a/b pulse once each.
- Slot A active at 3, assert hit_a for 1 clock: score goes 0->1, target_a=NO_TARGET next clock. With rand_num=7, target_a=7 after exactly RESPAWN_GAP+1 clocks.
- rand_num held at 12, then at target_b's value, then at 2: both rejected values keep the slot in SPAWN, and 2 is accepted.
- timer_done_a=1 while A is active, no hit: target_a clears, score unchanged. timer_done_a already high at the start pulse is ignored for 2 clocks.
- hit_a and hit_b in the same clock: score +2. Next, timer_done_c together with hit_a: game_over=1, score unchanged, both targets NO_TARGET.
- Pull reset low mid-PLAY with score=9: all outputs return to reset values asynchronously. With TARGET_SPEEDUP_EN and score=16, the next spawn has timer_len_a = TARGET_LEN>>2.

Source files
------------

// File: rtl/target_scheduler.sv
// target_scheduler: game sequencer for two target slots (A, B) and three timers.
// Optional TARGET_SPEEDUP_EN: target lifetime shrinks as the score grows.
//
// Ports:
//   clock, reset (async, active-low)
//   start_game           - level, starts a game from IDLE or OVER
//   rand_num[3:0]        - random candidate for spawning targets
//   hit_a, hit_b         - current target in that slot was hit
//   timer_done_a/b/c     - timer expired (a/b per slot, c whole game)
//   timer_start_a/b/c    - one-clock load pulse for the matching timer
//   timer_len_a/b/c      - length presented with the load pulse
//   target_a, target_b   - active target index, or NO_TARGET
//   score                - running score
//   game_over, playing   - top state flags
module target_scheduler #(
    parameter int unsigned NUM_TARGETS = 10,
    parameter logic [3:0]  NO_TARGET   = 4'hF,
    parameter logic [31:0] TARGET_LEN  = 32'd50_000_000,
    parameter logic [31:0] GAME_LEN    = 32'd1_500_000_000,
    parameter logic [31:0] HIT_POINTS  = 32'd1,
    parameter int unsigned RESPAWN_GAP = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_game,
    input  logic [3:0]  rand_num,
    input  logic        hit_a,
    input  logic        hit_b,
    input  logic        timer_done_a,
    input  logic        timer_done_b,
    input  logic        timer_done_c,
    output logic        timer_start_a,
    output logic        timer_start_b,
    output logic        timer_start_c,
    output logic [31:0] timer_len_a,
    output logic [31:0] timer_len_b,
    output logic [31:0] timer_len_c,
    output logic [3:0]  target_a,
    output logic [3:0]  target_b,
    output logic [31:0] score,
    output logic        game_over,
    output logic        playing
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} top_t;
    typedef enum logic [1:0] {EMPTY, SPAWN, ACTIVE, GAP} slot_t;

    localparam logic [4:0] NUM_T    = 5'(NUM_TARGETS);
    localparam logic [7:0] GAP_LAST = 8'(RESPAWN_GAP - 1);

    top_t        state;
    slot_t       slot_a, slot_b;
    logic [7:0]  gap_a, gap_b;
    // Timer outputs may be stale right after a load; done is ignored
    // while the matching blanking counter is non-zero.
    logic [1:0]  blank_a, blank_b, blank_c;

    logic        in_play;
    logic        game_end;
    logic        cand_ok;
    logic        a_accept, b_accept;
    logic [3:0]  a_next;
    logic        hit_a_ev, hit_b_ev;
    logic        tout_a_ev, tout_b_ev;
    logic [31:0] score_inc;
    logic [31:0] slot_len;

    always_comb begin
        in_play   = (state == PLAY);
        game_end  = in_play && timer_done_c && (blank_c == 2'd0);
        cand_ok   = ({1'b0, rand_num} < NUM_T);
        a_accept  = in_play && !game_end && (slot_a == SPAWN)
                    && cand_ok && (rand_num != target_b);
        // B sees A's freshly accepted value so both never collide.
        a_next    = a_accept ? rand_num : target_a;
        b_accept  = in_play && !game_end && (slot_b == SPAWN)
                    && cand_ok && (rand_num != a_next);
        hit_a_ev  = in_play && !game_end && (slot_a == ACTIVE) && hit_a;
        hit_b_ev  = in_play && !game_end && (slot_b == ACTIVE) && hit_b;
        tout_a_ev = in_play && !game_end && (slot_a == ACTIVE) && !hit_a
                    && timer_done_a && (blank_a == 2'd0);
        tout_b_ev = in_play && !game_end && (slot_b == ACTIVE) && !hit_b
                    && timer_done_b && (blank_b == 2'd0);
        score_inc = (hit_a_ev ? HIT_POINTS : 32'd0)
                  + (hit_b_ev ? HIT_POINTS : 32'd0);
    end

`ifdef TARGET_SPEEDUP_EN
    // Lifetime halves every 8 points, floored at TARGET_LEN/8.
    logic [1:0] shamt;
    always_comb begin
        shamt    = (|score[31:5]) ? 2'd3 : score[4:3];
        slot_len = TARGET_LEN >> shamt;
    end
`else
    always_comb begin
        slot_len = TARGET_LEN;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            slot_a        <= EMPTY;
            slot_b        <= EMPTY;
            gap_a         <= '0;
            gap_b         <= '0;
            blank_a       <= '0;
            blank_b       <= '0;
            blank_c       <= '0;
            target_a      <= NO_TARGET;
            target_b      <= NO_TARGET;
            score         <= '0;
            timer_start_a <= 1'b0;
            timer_start_b <= 1'b0;
            timer_start_c <= 1'b0;
            timer_len_a   <= '0;
            timer_len_b   <= '0;
            timer_len_c   <= '0;
            game_over     <= 1'b0;
            playing       <= 1'b0;
        end else begin
            timer_start_a <= 1'b0;
            timer_start_b <= 1'b0;
            timer_start_c <= 1'b0;
            unique case (state)
                IDLE, OVER: begin
                    if (start_game) begin
                        state         <= PLAY;
                        score         <= '0;
                        timer_start_c <= 1'b1;
                        timer_len_c   <= GAME_LEN;
                        blank_c       <= 2'd2;
                        slot_a        <= SPAWN;
                        slot_b        <= SPAWN;
                        gap_a         <= '0;
                        gap_b         <= '0;
                        target_a      <= NO_TARGET;
                        target_b      <= NO_TARGET;
                        playing       <= 1'b1;
                        game_over     <= 1'b0;
                    end
                end
                PLAY: begin
                    if (game_end) begin
                        state     <= OVER;
                        slot_a    <= EMPTY;
                        slot_b    <= EMPTY;
                        gap_a     <= '0;
                        gap_b     <= '0;
                        target_a  <= NO_TARGET;
                        target_b  <= NO_TARGET;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        score <= score + score_inc;
                        if (blank_c != 2'd0) blank_c <= blank_c - 2'd1;
                        if (blank_a != 2'd0) blank_a <= blank_a - 2'd1;
                        if (blank_b != 2'd0) blank_b <= blank_b - 2'd1;

                        unique case (slot_a)
                            SPAWN: begin
                                if (a_accept) begin
                                    target_a      <= rand_num;
                                    timer_start_a <= 1'b1;
                                    timer_len_a   <= slot_len;
                                    blank_a       <= 2'd2;
                                    slot_a        <= ACTIVE;
                                end
                            end
                            ACTIVE: begin
                                if (hit_a_ev || tout_a_ev) begin
                                    target_a <= NO_TARGET;
                                    gap_a    <= '0;
                                    slot_a   <= GAP;
                                end
                            end
                            GAP: begin
                                if (gap_a == GAP_LAST) begin
                                    gap_a  <= '0;
                                    slot_a <= SPAWN;
                                end else begin
                                    gap_a <= gap_a + 8'd1;
                                end
                            end
                            default: ;
                        endcase

                        unique case (slot_b)
                            SPAWN: begin
                                if (b_accept) begin
                                    target_b      <= rand_num;
                                    timer_start_b <= 1'b1;
                                    timer_len_b   <= slot_len;
                                    blank_b       <= 2'd2;
                                    slot_b        <= ACTIVE;
                                end
                            end
                            ACTIVE: begin
                                if (hit_b_ev || tout_b_ev) begin
                                    target_b <= NO_TARGET;
                                    gap_b    <= '0;
                                    slot_b   <= GAP;
                                end
                            end
                            GAP: begin
                                if (gap_b == GAP_LAST) begin
                                    gap_b  <= '0;
                                    slot_b <= SPAWN;
                                end else begin
                                    gap_b <= gap_b + 8'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
